reg_dump: RTL and testbench
===========================

// Module: reg_dump
// PURPOSE
//  Debug read-out engine for the register file. On a start pulse it walks every
//  register from address 0 to 2**N-1 through a spare asynchronous read port.
//  Each register is emitted as one {address, data} word on a valid/ready stream.
//  Sits beside reg_file and feeds the debug/trace path; it never writes the file.
// PARAMETERS
//  N  5   register address width; the file holds 2**N registers
//  M  32  register data width
// PORTS
//  clk      in   1  clock; all state changes on the rising edge
//  rst      in   1  synchronous, active-high reset
//  start    in   1  begin a dump; sampled only in IDLE
//  rdAddr   out  N  address to the register file's spare read port
//  rdData   in   M  asynchronous read data returned for rdAddr
//  outValid out  1  outAddr/outData/outLast hold a valid word
//  outReady in   1  consumer accepts the word when outValid && outReady
//  outAddr  out  N  register address of the current word
//  outData  out  M  register contents of the current word
//  outLast  out  1  current word is address 2**N-1
//  busy     out  1  high in every state except IDLE
//  done     out  1  one-cycle pulse after the last word is accepted
// BEHAVIOUR
//  Reset (rst=1 at an edge) forces the following values, regardless of state:
//   - state=IDLE, addr=0, outValid=0, outAddr=0, outData=0, outLast=0, busy=0, done=0.
//   - rdAddr=0.
//  States: IDLE, LOAD, SEND, DONE.
//  IDLE: if start=1, set addr=0 and go to LOAD.
//  LOAD:
//   - rdAddr=addr.
//   - At the edge: outData<=rdData, outAddr<=addr, outLast<=(addr==2**N-1), outValid<=1.
//   - Go to SEND.
//  SEND:
//   - outValid=1; outAddr, outData and outLast are held stable until the handshake.
//   - On outValid&&outReady: outValid<=0. If outLast, go to DONE; else addr<=addr+1 and go to LOAD.
//  DONE: done=1 for exactly this cycle, then go to IDLE. busy=1.
//  rdAddr equals addr in every state (0 in IDLE).
//  Latency:
//   - start seen at edge k -> LOAD during cycle k+1 -> outValid=1 from cycle k+2.
//   - Minimum 2 cycles per word, so a full dump takes 2*2**N cycles plus the DONE cycle.
//  Arithmetic: addr is N bits. It never wraps, because the dump ends at 2**N-1.
//  start while busy=1: ignored; no restart and no queued request.
//  start in the same cycle as done: ignored, because the FSM is not in IDLE.
//  outReady while outValid=0: ignored.
//  Consistency with concurrent writes:
//   - Each word is the register value present on rdData in its LOAD cycle.
//   - A write at that same edge is not reflected in the word.
//   - There is no snapshot across the whole file; a concurrent write only changes later words.
//  Reset mid-dump: the word in flight is dropped and outValid=0 on the next cycle.
//   No done pulse is produced. The next start dumps from address 0 again.
//  outValid never drops without a handshake, except on reset.
// TESTING
//  1. Reset values:
//     - Hold rst=1 for 2 cycles with start=1.
//     - Required: all outputs 0 and IDLE.
//     - Required after rst falls with start still 1: busy=1 next cycle.
//  2. Full dump, no backpressure:
//     - Preload reg[i]=0x1000+i, outReady=1, then pulse start.
//     - Required: 32 words with addr 0..31 and data 0x1000..0x101F, in order.
//     - Required: outLast=1 only on addr 31.
//     - Required: done pulses once, 1 cycle after the last handshake; total 65 cycles from start.
//  3. Backpressure:
//     - Drop outReady for 3 cycles while word addr 5 (0x1005) is valid.
//     - Required: outValid, outAddr and outData stay stable for those cycles.
//     - Required: 0x1005 is emitted exactly once and addr 6 follows.
//  4. start while busy:
//     - Pulse start again during word 10.
//     - Required: the sequence is unaffected and there is one done pulse only.
//  5. Reset mid-dump:
//     - Assert rst during word 10.
//     - Required: outValid=0 next cycle and no done pulse.
//     - Required: a new start yields addr 0 first.
//  6. Concurrent write, N=2, M=8:
//     - Write reg[3]=0xAA while word 1 is in SEND.
//     - Required: 4 words are emitted and word 3 data is 0xAA.

Source files
------------

// File: rtl/reg_dump.sv
// Debug read-out engine: walks every register of the file through a spare async
// read port and streams {address, data} words on a valid/ready interface.
module reg_dump #(
  parameter int unsigned N = 5,
  parameter int unsigned M = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  output logic [N-1:0] rd_addr_o,
  input  logic [M-1:0] rd_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [N-1:0] out_addr_o,
  output logic [M-1:0] out_data_o,
  output logic         out_last_o,
  output logic         busy_o,
  output logic         done_o
);

  localparam logic [N-1:0] LAST_ADDR = {N{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e       state_q, state_d;
  logic [N-1:0] addr_q, addr_d;
  logic         out_valid_q, out_valid_d;
  logic [N-1:0] out_addr_q, out_addr_d;
  logic [M-1:0] out_data_q, out_data_d;
  logic         out_last_q, out_last_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  // State and output registers; reset drops any word in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state and output logic; the word is captured from the read port in LOAD.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          addr_d  = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        out_data_d  = rd_data_i;
        out_addr_d  = addr_q;
        out_last_d  = (addr_q == LAST_ADDR);
        out_valid_d = 1'b1;
        state_d     = SEND;
      end
      SEND: begin
        if (out_valid_q && out_ready_i) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            state_d = DONE;
          end else begin
            addr_d  = addr_q + N'(1);
            state_d = LOAD;
          end
        end
      end
      DONE: begin
        // Park the read address at 0 so it reads 0 whenever idle.
        addr_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  assign rd_addr_o   = addr_q;
  assign out_valid_o = out_valid_q;
  assign out_addr_o  = out_addr_q;
  assign out_data_o  = out_data_q;
  assign out_last_o  = out_last_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_reg_dump.sv
// Self-checking bench for reg_dump: per-cycle reference model plus directed
// scenarios on a 32x32 instance and a 4x8 instance.
module tb_reg_dump;

  localparam int unsigned N  = 5;
  localparam int unsigned M  = 32;
  localparam int unsigned NB = 2;
  localparam int unsigned MB = 8;
  localparam int LAST = 31;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b1;
  logic ready = 1'b1;
  logic [N-1:0] rd_addr;
  logic [M-1:0] rd_data;
  logic out_valid, out_last, busy, done;
  logic [N-1:0] out_addr;
  logic [M-1:0] out_data;

  logic start_b = 1'b0;
  logic ready_b = 1'b1;
  logic [NB-1:0] rd_addr_b;
  logic [MB-1:0] rd_data_b;
  logic out_valid_b, out_last_b, busy_b, done_b;
  logic [NB-1:0] out_addr_b;
  logic [MB-1:0] out_data_b;

  logic [M-1:0]  rf   [32];
  logic [MB-1:0] rf_b [4];

  assign rd_data   = rf[rd_addr];
  assign rd_data_b = rf_b[rd_addr_b];

  always #5 clk = ~clk;

  reg_dump #(.N(N), .M(M)) u_dut (
    .clk(clk), .rst(rst), .start_i(start),
    .rd_addr_o(rd_addr), .rd_data_i(rd_data),
    .out_valid_o(out_valid), .out_ready_i(ready),
    .out_addr_o(out_addr), .out_data_o(out_data), .out_last_o(out_last),
    .busy_o(busy), .done_o(done)
  );

  reg_dump #(.N(NB), .M(MB)) u_dut_b (
    .clk(clk), .rst(rst), .start_i(start_b),
    .rd_addr_o(rd_addr_b), .rd_data_i(rd_data_b),
    .out_valid_o(out_valid_b), .out_ready_i(ready_b),
    .out_addr_o(out_addr_b), .out_data_o(out_data_b), .out_last_o(out_last_b),
    .busy_o(busy_b), .done_o(done_b)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: a dump is a list of words; each word appears two cycles
  // after the start or the previous acceptance, done one cycle after the last.
  bit chk_en = 1'b0;
  bit m_busy = 1'b0;
  bit m_done = 1'b0;
  int m_idx  = 0;
  int m_vfrom = 0;

  always @(negedge clk) begin
    bit ev;
    ev = m_busy && !m_done && (cyc >= m_vfrom);
    if (chk_en) begin
      chk("m_busy",  64'(busy), 64'(m_busy));
      chk("m_done",  64'(done), 64'(m_done));
      chk("m_valid", 64'(out_valid), 64'(ev));
      chk("m_rdaddr", 64'(rd_addr), m_busy ? 64'(m_idx) : 64'd0);
      if (ev) begin
        chk("m_addr", 64'(out_addr), 64'(m_idx));
        chk("m_data", 64'(out_data), 64'(rf[m_idx]));
        chk("m_last", 64'(out_last), 64'(m_idx == LAST));
      end
    end
    if (rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_idx = 0;
    end else if (m_done) begin
      m_busy = 1'b0; m_done = 1'b0; m_idx = 0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy = 1'b1; m_idx = 0; m_vfrom = cyc + 2;
      end
    end else if (ev && ready) begin
      if (m_idx == LAST) m_done = 1'b1;
      else begin
        m_idx++; m_vfrom = cyc + 2;
      end
    end
  end

  // Stream monitors
  logic [N-1:0]  acc_q [$];
  logic [M-1:0]  dat_q [$];
  logic [MB-1:0] dat_b_q [$];
  int done_cnt = 0, done_cyc = 0, start_cyc = 0, done_b_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && ready) begin
        acc_q.push_back(out_addr);
        dat_q.push_back(out_data);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (out_valid_b && ready_b) dat_b_q.push_back(out_data_b);
      if (done_b) done_b_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_mon();
    acc_q.delete(); dat_q.delete(); dat_b_q.delete();
    done_cnt = 0; done_b_cnt = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk); start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_word(input int a);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (out_valid && (int'(out_addr) == a)) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) chk("wait_word_timeout", 64'd0, 64'd1);
  endtask

  function automatic int order_errors();
    int bad;
    bad = 0;
    for (int i = 0; i < acc_q.size(); i++) begin
      if (int'(acc_q[i]) != i) bad++;
      if (dat_q[i] != 32'h1000 + 32'(i)) bad++;
    end
    return bad;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + 32'(i);
    for (int i = 0; i < 4; i++) rf_b[i] = 8'h10 + 8'(i);

    // 1. reset with start held high
    @(posedge clk); @(posedge clk); #1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("t1_valid", 64'(out_valid), 64'd0);
    chk("t1_addr",  64'(out_addr), 64'd0);
    chk("t1_data",  64'(out_data), 64'd0);
    chk("t1_last",  64'(out_last), 64'd0);
    chk("t1_busy",  64'(busy), 64'd0);
    chk("t1_done",  64'(done), 64'd0);
    chk("t1_rdaddr", 64'(rd_addr), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("t1_busy_after", 64'(busy), 64'd1);
    repeat (80) tick();

    // 2. full dump without backpressure
    clear_mon();
    pulse_start();
    repeat (80) tick();
    chk("t2_count", 64'(acc_q.size()), 64'd32);
    if (acc_q.size() == 32) begin
      chk("t2_order", 64'(order_errors()), 64'd0);
      chk("t2_first_data", 64'(dat_q[0]), 64'h1000);
      chk("t2_last_data", 64'(dat_q[31]), 64'h101F);
    end
    chk("t2_done_cnt", 64'(done_cnt), 64'd1);
    chk("t2_latency", 64'(done_cyc - start_cyc), 64'd65);

    // 3. backpressure on word 5
    clear_mon();
    pulse_start();
    wait_word(5);
    ready = 1'b0;
    repeat (3) begin
      chk("t3_hold_valid", 64'(out_valid), 64'd1);
      chk("t3_hold_addr",  64'(out_addr), 64'd5);
      chk("t3_hold_data",  64'(out_data), 64'h1005);
      tick();
    end
    ready = 1'b1;
    repeat (100) tick();
    begin
      int n5;
      n5 = 0;
      foreach (acc_q[i]) if (acc_q[i] == 5'd5) n5++;
      chk("t3_once", 64'(n5), 64'd1);
    end
    chk("t3_count", 64'(acc_q.size()), 64'd32);
    if (acc_q.size() == 32) chk("t3_next", 64'(acc_q[6]), 64'd6);
    chk("t3_done_cnt", 64'(done_cnt), 64'd1);

    // 4. start while busy
    clear_mon();
    pulse_start();
    wait_word(10);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (100) tick();
    chk("t4_count", 64'(acc_q.size()), 64'd32);
    if (acc_q.size() == 32) chk("t4_order", 64'(order_errors()), 64'd0);
    chk("t4_done_cnt", 64'(done_cnt), 64'd1);

    // 5. reset mid-dump, then restart
    clear_mon();
    pulse_start();
    wait_word(10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_valid_drop", 64'(out_valid), 64'd0);
    repeat (10) tick();
    chk("t5_no_done", 64'(done_cnt), 64'd0);
    pulse_start();
    begin
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (out_valid) begin
          ok = 1'b1;
          break;
        end
        tick();
      end
      chk("t5_restart_seen", 64'(ok), 64'd1);
      chk("t5_restart_addr", 64'(out_addr), 64'd0);
    end
    repeat (100) tick();
    chk("t5_done_cnt", 64'(done_cnt), 64'd1);

    // 6. concurrent write on the small instance
    clear_mon();
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    begin
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (out_valid_b && out_addr_b == 2'd1) begin
          ok = 1'b1;
          break;
        end
        tick();
      end
      chk("t6_word1_seen", 64'(ok), 64'd1);
    end
    rf_b[3] = 8'hAA;
    repeat (20) tick();
    chk("t6_count", 64'(dat_b_q.size()), 64'd4);
    if (dat_b_q.size() == 4) begin
      chk("t6_w0", 64'(dat_b_q[0]), 64'h10);
      chk("t6_w1", 64'(dat_b_q[1]), 64'h11);
      chk("t6_w2", 64'(dat_b_q[2]), 64'h12);
      chk("t6_w3", 64'(dat_b_q[3]), 64'hAA);
    end
    chk("t6_done_cnt", 64'(done_b_cnt), 64'd1);
    chk("t6_idle", 64'(busy_b), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
